// File: rtl/cp0_int_unit.sv
// cp0_int_unit -- coprocessor-0 interrupt/exception unit, M stage.
//
// Holds SR, Cause, EPC and PRId. Each cycle it decides whether the core must
// flush and jump to the handler.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   we, addr, din        mtc0 write strobe, register number, write data
//   dout                 mfc0 read data (combinational, pre-edge value)
//   vpc, bd_in           M-stage PC and branch-delay-slot flag
//   exc_code_in          pipelined exception code, 0 = none
//   hw_int               level-sensitive hardware interrupt lines
//   eret                 eret in M stage
//   req                  flush and redirect fetch to handler_pc
//   handler_pc           constant handler entry address
//   epc_out              current EPC, used for the eret redirect
module cp0_int_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VALUE   = 32'h2023_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    // SR fields
    logic [5:0]  sr_im_reg;
    logic        sr_exl_reg;
    logic        sr_ie_reg;
    // Cause fields
    logic        cause_bd_reg;
    logic [5:0]  cause_ip_reg;
    logic [4:0]  cause_exc_reg;
    // EPC
    logic [31:0] epc_reg;

    logic [5:0]  pending;
    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_value;
    logic [31:0] cause_value;
    logic [31:0] epc_next;

    // One pending bit per line: raised and unmasked in IM.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_pending
            assign pending[gi] = hw_int[gi] & sr_im_reg[gi];
        end
    endgenerate

    // EXL masks both sources, so a request lasts exactly one cycle.
    assign int_req = (|pending) & sr_ie_reg & ~sr_exl_reg;
    assign exc_req = (exc_code_in != 5'd0) & ~sr_exl_reg;
    assign req     = int_req | exc_req;

    // A faulting instruction in a delay slot restarts at its branch.
    assign epc_next = bd_in ? (vpc - 32'd4) : vpc;

    assign sr_value    = {16'd0, sr_im_reg, 8'd0, sr_exl_reg, sr_ie_reg};
    assign cause_value = {cause_bd_reg, 15'd0, cause_ip_reg, 3'd0,
                          cause_exc_reg, 2'd0};

    assign handler_pc = HANDLER_ADDR;
    assign epc_out    = epc_reg;

    always_comb begin
        dout = 32'd0;
        case (addr)
            ADDR_SR:    dout = sr_value;
            ADDR_CAUSE: dout = cause_value;
            ADDR_EPC:   dout = epc_reg;
            ADDR_PRID:  dout = PRID_VALUE;
            default:    dout = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_reg     <= 6'd0;
            sr_exl_reg    <= 1'b0;
            sr_ie_reg     <= 1'b0;
            cause_bd_reg  <= 1'b0;
            cause_ip_reg  <= 6'd0;
            cause_exc_reg <= 5'd0;
            epc_reg       <= 32'd0;
        end else begin
            // IP mirrors the raw lines regardless of masking or handler state.
            cause_ip_reg <= hw_int;
            if (req) begin
                // Entering the handler; any mtc0 this cycle is dropped.
                sr_exl_reg    <= 1'b1;
                cause_exc_reg <= int_req ? 5'd0 : exc_code_in;
                cause_bd_reg  <= bd_in;
                epc_reg       <= epc_next;
            end else begin
                if (eret) begin
                    sr_exl_reg <= 1'b0;
                end
                if (we) begin
                    case (addr)
                        ADDR_SR: begin
                            // eret owns EXL this cycle, so the SR write is lost.
                            if (!eret) begin
                                sr_im_reg  <= din[15:10];
                                sr_exl_reg <= din[1];
                                sr_ie_reg  <= din[0];
                            end
                        end
                        ADDR_EPC: epc_reg <= din;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_int_unit.sv
module tb_cp0_int_unit;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        eret;
        logic        chk;
        logic        exp_req;
        logic [31:0] exp_dout;
        logic [31:0] exp_epc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cp0_int_unit dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .din(din),
        .dout(dout), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
        .hw_int(hw_int), .eret(eret), .req(req), .handler_pc(handler_pc),
        .epc_out(epc_out)
    );

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [31:0] pc,
                       input logic b, input logic [4:0] e, input logic [5:0] h,
                       input logic er, input logic c, input logic xr,
                       input logic [31:0] xd, input logic [31:0] xe);
        vec_t v;
        v.rst = r; v.we = w; v.addr = a; v.din = d; v.vpc = pc; v.bd = b;
        v.exc = e; v.hw = h; v.eret = er; v.chk = c; v.exp_req = xr;
        v.exp_dout = xd; v.exp_epc = xe;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; we = v.we; addr = v.addr; din = v.din; vpc = v.vpc;
        bd_in = v.bd; exc_code_in = v.exc; hw_int = v.hw; eret = v.eret;
    endtask

    initial begin
        //   rst we addr din           vpc           bd exc    hw       eret chk req dout          epc
        // reset and read-back
        add(1, 0, 5'd0,  32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 0, 0, 32'h0,         32'h0);
        add(0, 0, 5'd12, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0,         32'h0);
        add(0, 0, 5'd13, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0,         32'h0);
        add(0, 0, 5'd14, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0,         32'h0);
        add(0, 0, 5'd15, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h2023_0007, 32'h0);
        add(0, 0, 5'd0,  32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0,         32'h0);
        // masked external line, then unmask -> one-cycle request
        add(0, 1, 5'd12, 32'h0000_0401,32'h3010,     0, 5'd0,  6'b000000, 0, 1, 0, 32'h0,         32'h0);
        add(0, 0, 5'd12, 32'h0,        32'h3010,     0, 5'd0,  6'b000100, 0, 1, 0, 32'h0000_0401, 32'h0);
        add(0, 1, 5'd12, 32'h0000_1001,32'h3010,     0, 5'd0,  6'b000100, 0, 1, 0, 32'h0000_0401, 32'h0);
        add(0, 0, 5'd12, 32'h0,        32'h3010,     0, 5'd0,  6'b000100, 0, 1, 1, 32'h0000_1001, 32'h0);
        add(0, 0, 5'd13, 32'h0,        32'h3010,     0, 5'd0,  6'b000100, 0, 1, 0, 32'h0000_1000, 32'h3010);
        add(0, 0, 5'd14, 32'h0,        32'h3010,     0, 5'd0,  6'b000100, 0, 1, 0, 32'h0000_3010, 32'h3010);
        add(0, 0, 5'd12, 32'h0,        32'h3010,     0, 5'd0,  6'b000100, 0, 1, 0, 32'h0000_1003, 32'h3010);
        // eret after ack, then line re-raised
        add(0, 0, 5'd12, 32'h0,        32'h3010,     0, 5'd0,  6'b000000, 1, 1, 0, 32'h0000_1003, 32'h3010);
        add(0, 0, 5'd12, 32'h0,        32'h3040,     0, 5'd0,  6'b000100, 0, 1, 1, 32'h0000_1001, 32'h3010);
        add(0, 0, 5'd14, 32'h0,        32'h3040,     0, 5'd0,  6'b000100, 0, 1, 0, 32'h0000_3040, 32'h3040);
        // mtc0 SR together with eret: SR write lost
        add(0, 1, 5'd12, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 1, 1, 0, 32'h0000_1003, 32'h3040);
        add(0, 0, 5'd12, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0000_1001, 32'h3040);
        // exception in delay slot with IE=0
        add(0, 1, 5'd12, 32'h0000_1000,32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0000_1001, 32'h3040);
        add(0, 0, 5'd12, 32'h0,        32'h3024,     1, 5'd4,  6'b000000, 0, 1, 1, 32'h0000_1000, 32'h3040);
        add(0, 0, 5'd13, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h8000_0010, 32'h3020);
        add(0, 0, 5'd14, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0000_3020, 32'h3020);
        add(0, 0, 5'd12, 32'h0,        32'h3030,     0, 5'd4,  6'b000000, 0, 1, 0, 32'h0000_1002, 32'h3020);
        // mtc0 EPC during a request is dropped; mtc0 Cause ignored
        add(0, 0, 5'd12, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 1, 1, 0, 32'h0000_1002, 32'h3020);
        add(0, 1, 5'd14, 32'h0000_1234,32'h3050,     0, 5'd8,  6'b000000, 0, 1, 1, 32'h0000_3020, 32'h3020);
        add(0, 0, 5'd14, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0000_3050, 32'h3050);
        add(0, 1, 5'd13, 32'hffff_ffff,32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0000_0020, 32'h3050);
        add(0, 0, 5'd13, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0000_0020, 32'h3050);
        add(0, 1, 5'd14, 32'h0000_1234,32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0000_3050, 32'h3050);
        add(0, 0, 5'd14, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0000_1234, 32'h1234);
        // SR write masking, then interrupt beats exception
        add(0, 0, 5'd12, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 1, 1, 0, 32'h0000_1002, 32'h1234);
        add(0, 1, 5'd12, 32'hffff_fffd,32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0000_1000, 32'h1234);
        add(0, 0, 5'd12, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0000_fc01, 32'h1234);
        add(0, 0, 5'd12, 32'h0,        32'h3060,     0, 5'd12, 6'b000100, 0, 1, 1, 32'h0000_fc01, 32'h1234);
        add(0, 0, 5'd13, 32'h0,        32'h0,        0, 5'd0,  6'b000100, 0, 1, 0, 32'h0000_1000, 32'h3060);
        // reset one cycle later clears everything
        add(1, 0, 5'd0,  32'h0,        32'h0,        0, 5'd0,  6'b000100, 0, 0, 0, 32'h0,         32'h0);
        add(0, 0, 5'd12, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0,         32'h0);
        add(0, 0, 5'd13, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0,         32'h0);
        add(0, 0, 5'd14, 32'h0,        32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0,         32'h0);
        // EPC wrap-around: delay slot at vpc=0 via Timer0
        add(0, 1, 5'd12, 32'h0000_0401,32'h0,        0, 5'd0,  6'b000000, 0, 1, 0, 32'h0,         32'h0);
        add(0, 0, 5'd14, 32'h0,        32'h0,        1, 5'd0,  6'b000001, 0, 1, 1, 32'h0,         32'h0);
        add(0, 0, 5'd14, 32'h0,        32'h0,        0, 5'd0,  6'b000001, 0, 1, 0, 32'hffff_fffc, 32'hffff_fffc);
        add(0, 0, 5'd13, 32'h0,        32'h0,        0, 5'd0,  6'b000001, 0, 1, 0, 32'h8000_0400, 32'hffff_fffc);
        // eret without ack: level line re-fires right away
        add(0, 0, 5'd12, 32'h0,        32'h0,        0, 5'd0,  6'b000001, 1, 1, 0, 32'h0000_0403, 32'hffff_fffc);
        add(0, 0, 5'd12, 32'h0,        32'h0000_0010,0, 5'd0,  6'b000001, 0, 1, 1, 32'h0000_0401, 32'hffff_fffc);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            #2;
            if (vecs[i].chk) begin
                $display("vec %0d: addr=%0d req=%b dout=%h epc=%h",
                         i, addr, req, dout, epc_out);
                cmp($sformatf("v%0d_req", i),  {31'd0, req}, {31'd0, vecs[i].exp_req});
                cmp($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
                cmp($sformatf("v%0d_epc", i),  epc_out, vecs[i].exp_epc);
            end
            @(posedge clk);
            #1;
        end

        // Handler active (EPC=0x10, EXL=1), line still high: reset mid-handler.
        cmp("pre_reset_epc", epc_out, 32'h0000_0010);
        cmp("handler_pc", handler_pc, 32'h0000_4180);
        reset = 1'b1; we = 1'b0; eret = 1'b0; exc_code_in = 5'd0;
        hw_int = 6'b000001;
        @(posedge clk);
        #1;
        reset = 1'b0; addr = 5'd12;
        #2;
        $display("mid-handler reset: req=%b sr=%h epc=%h", req, dout, epc_out);
        cmp("rst_mid_req", {31'd0, req}, 32'd0);
        cmp("rst_mid_sr", dout, 32'h0);
        cmp("rst_mid_epc", epc_out, 32'h0);
        @(posedge clk);
        #1;
        cmp("rst_after_req", {31'd0, req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cp0_int_unit.md
Name: cp0_int_unit

Overview:
- Coprocessor-0 block inside the pipelined MIPS core, placed at the M stage.
- It is the CPU-side responder to the external interrupt line and to internal exceptions.
- It holds SR, Cause, EPC and PRId, and decides each cycle whether the core must flush and jump to the handler.
- The bridge maps the external interrupt source to hw_int[2]. The handler acknowledges that source by storing to 0x7f20, which is outside this block.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry PC driven on handler_pc.
- PRID_VALUE, 32'h2023_0007, constant returned when PRId (reg 15) is read.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- we  in  1  mtc0 write strobe from M stage.
- addr  in  5  CP0 register number for mtc0/mfc0.
- din  in  32  mtc0 write data.
- dout  out  32  mfc0 read data (combinational).
- vpc  in  32  macroscopic PC of the M-stage instruction, word aligned.
- bd_in  in  1  M-stage instruction sits in a branch delay slot.
- exc_code_in  in  5  pipelined exception code; 0 means no exception.
- hw_int  in  6  hardware interrupt lines: [0] Timer0, [1] Timer1, [2] external interrupt.
- eret  in  1  eret in M stage.
- req  out  1  flush pipeline and redirect fetch to handler_pc.
- handler_pc  out  32  constant HANDLER_ADDR.
- epc_out  out  32  current EPC, for eret redirect.

Behaviour:
- Register fields:
  - SR: IM=[15:10], EXL=[1], IE=[0]. All other SR bits read 0.
  - Cause: BD=[31], IP=[15:10], ExcCode=[6:2]. All other Cause bits read 0.
  - EPC: 32-bit.
- Reset (at posedge when reset=1): SR=0, Cause=0, EPC=0. Outputs after reset: req=0, dout=0 for addr 12/13/14, epc_out=0.
- Request decode (combinational, same cycle):
  - int_req = |(hw_int & IM) & IE & ~EXL
  - exc_req = (exc_code_in != 0) & ~EXL
  - req = int_req | exc_req
  - Interrupt has priority over exception.
- Update at a posedge with req=1:
  - EXL<=1.
  - ExcCode <= int_req ? 0 : exc_code_in.
  - BD <= bd_in.
  - EPC <= bd_in ? vpc-4 : vpc (32-bit wrap-around subtraction).
  - Because EXL is then set, req falls on the next cycle. A single request lasts exactly one cycle even if hw_int stays high.
- Priority at a posedge: req > eret > mtc0.
  - eret (with req=0): EXL<=0.
  - mtc0 while req=1 is discarded.
  - mtc0 concurrent with eret: eret clears EXL, and the mtc0 is still applied to registers other than SR.
- mtc0 write rules:
  - addr 12: SR <= din masked to bits 15:10,1,0.
  - addr 14: EPC <= din.
  - addr 13, 15 and other addresses: ignored.
- IP tracking: Cause.IP <= hw_int every cycle, unconditionally, including while EXL=1 and in a req cycle. It is not written by mtc0.
- Reads (mfc0): dout = SR / Cause / EPC / PRID_VALUE for addr 12 / 13 / 14 / 15, 0 otherwise. Reads return the pre-edge value, with no internal write-to-read bypass.
- EXL=1 masks everything, including exceptions (no nested handling).
- hw_int is level-sensitive. The source holds it until the handler's 0x7f20 store, so the handler must ack before eret or the interrupt re-fires on the first cycle after EXL clears.
- Reset asserted mid-handler clears EXL and EPC immediately, and req is 0 in that cycle's aftermath.

Test Plan:
1. Reset, then read addr 12/13/14/15 -> 0, 0, 0, 32'h2023_0007; req=0.
2. Write SR=32'h0000_0401 (IM[10]=1, IE=1), vpc=32'h3010, bd_in=0, raise hw_int[2] -> req=0 (line masked). Then write SR=32'h0000_1001 -> req=1 for exactly one cycle; next cycle Cause=32'h0000_1000, EPC=32'h3010, SR=32'h0000_1003.
3. exc_code_in=5'd4 with vpc=32'h3024, bd_in=1, IE=0 -> req=1 (exceptions ignore IE); Cause=32'h8000_0010, EPC=32'h3020.
4. With EXL=1, drop hw_int and assert eret -> EXL=0, req stays 0. Then hw_int[2]=1 again -> req=1 on the following cycle.
5. mtc0 addr 14 din=32'h1234 in the same cycle as an exception req -> EPC=vpc, not 32'h1234. mtc0 addr 13 din=32'hffff_ffff -> Cause unchanged.
6. Simultaneous int_req and exc_code_in=5'd12 -> ExcCode=0 and EPC=vpc. Reset asserted one cycle later -> SR=Cause=EPC=0.
